intpol2_out_fifo: RTL and testbench
===================================

INTPOL2_OUT_FIFO -- requirements
Module: intpol2_out_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: sample word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4: depth DEPTH = 2**ADDR_WIDTH = 16.
REQ-003 SHALL have parameter AFULL_MARGIN, default 4: Afull asserts when count >= DEPTH - AFULL_MARGIN.
REQ-004 SHALL have port clk, input, 1 bit: the only clock, rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port clear, input, 1 bit: synchronous flush, driven from the interpolator FSM clear.
REQ-007 SHALL have port Write_Enable, input, 1 bit: write request from the interpolator stage.
REQ-008 SHALL have port wdata, input, DATA_WIDTH bits: interpolated sample to store.
REQ-009 SHALL have port Read_Enable, input, 1 bit: read request from the downstream consumer.
REQ-010 SHALL have port rdata, output, DATA_WIDTH bits: registered read data.
REQ-011 SHALL have port rvalid, output, 1 bit: rdata holds a newly read word this cycle.
REQ-012 SHALL have port Empty, output, 1 bit: count == 0.
REQ-013 SHALL have port Full, output, 1 bit: count == DEPTH.
REQ-014 SHALL have port Afull, output, 1 bit: almost-full backpressure to the interpolator FSM.
REQ-015 SHALL have port count, output, ADDR_WIDTH+1 bits: current occupancy.
REQ-016 SHALL have port overflow, output, 1 bit: sticky flag, set when a write is rejected.
REQ-017 SHALL have port underflow, output, 1 bit: sticky flag, set when a read is rejected.

Function
REQ-018 SHALL accept a write when Write_Enable=1 and (Full=0 or a read is accepted in the same cycle): store wdata at wr_ptr, then increment wr_ptr modulo DEPTH.
REQ-019 SHALL accept a read when Read_Enable=1 and Empty=0, with no write-to-read bypass: rdata = mem[rd_ptr] one cycle later with rvalid=1, then increment rd_ptr modulo DEPTH.
REQ-020 SHALL drive rvalid=0 in any cycle following a cycle with no accepted read; rdata SHALL hold its last value.
REQ-021 SHALL update count as follows: +1 on write only, -1 on read only, unchanged on simultaneous accepted write and read.
REQ-022 SHALL derive Empty, Full and Afull combinationally from the registered count, so each flag reflects an access on the next cycle.
REQ-023 SHALL, on a write with Full=1 and no accepted read, drop the data, leave pointers unchanged, and set overflow.
REQ-024 SHALL, on a read with Empty=1, leave rdata and rd_ptr unchanged, drive rvalid=0 next cycle, and set underflow, including when a write is accepted in the same cycle.
REQ-025 SHALL, on clear=1, set pointers, count, rvalid, overflow and underflow to 0 next cycle, discard accesses in that cycle, and leave memory contents unchanged.
REQ-026 SHALL clear overflow and underflow only by clear or rstn.
REQ-027 SHALL wrap pointers at DEPTH-1 to 0; count alone distinguishes full from empty.

Reset
REQ-028 SHALL, while rstn=0, force wr_ptr=0, rd_ptr=0, count=0, rdata=0, rvalid=0, overflow=0 and underflow=0, giving Empty=1, Full=0, Afull=0.
REQ-029 SHALL, on rstn assertion mid-operation, discard all stored data; memory need not be reset.

Structure
REQ-030 SHALL place the DATA_WIDTH, ADDR_WIDTH and AFULL_MARGIN defaults in shared package intpol2_pkg, reused by the interpolator datapath.
REQ-031 SHALL instantiate storage as one sub-module, intpol2_fifo_ram: a simple dual-port RAM with synchronous write and synchronous read and no reset.

Verification
REQ-032 SHALL cover fill: 16 writes of 0x1..0x10 -> count=16, Full=1, Afull=1 from count 12, Empty=0.
REQ-033 SHALL cover drain: 16 reads after fill -> rdata 0x1..0x10 in order, each with rvalid one cycle after Read_Enable; Empty=1 at end.
REQ-034 SHALL cover overflow: a 17th write of 0xDEAD when full -> overflow=1, count=16, 0xDEAD never read.
REQ-035 SHALL cover full with simultaneous read and write of 0x55 -> both accepted, count stays 16, 0x55 read out last.
REQ-036 SHALL cover empty read: read with simultaneous write of 0x7 -> underflow=1, rvalid=0, count=1, next read returns 0x7.
REQ-037 SHALL cover clear and reset: clear with count=9 -> count=0, flags cleared; rstn pulse mid-fill -> all outputs at reset values.

Source files
------------

// File: rtl/intpol2_pkg.sv
// intpol2_pkg: shared sizing defaults for the interpolator datapath and its output FIFO
package intpol2_pkg;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_ADDR_WIDTH   = 4;
    localparam int DEF_AFULL_MARGIN = 4;
endpackage

// File: rtl/intpol2_fifo_ram.sv
// intpol2_fifo_ram: simple dual-port RAM, synchronous write and read, no reset
module intpol2_fifo_ram #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    logic [DW-1:0] mem_q [2**AW];
    // same-address write and read in one cycle returns the old word
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_o <= mem_q[raddr_i];
    end
endmodule

// File: rtl/intpol2_out_fifo.sv
// intpol2_out_fifo: output sample FIFO between interpolator and downstream consumer
module intpol2_out_fifo
    import intpol2_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int AFULL_MARGIN = DEF_AFULL_MARGIN
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clear,
    input  logic                  Write_Enable,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  Read_Enable,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  Empty,
    output logic                  Full,
    output logic                  Afull,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LVL  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH+1)'(DEPTH - AFULL_MARGIN);
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  rvalid_q, rvalid_d, ovf_q, ovf_d, udf_q, udf_d;
    logic [DATA_WIDTH-1:0] rdata_q, ram_rdata;
    logic                  wr_ok, rd_ok;
    assign Empty     = count_q == '0;
    assign Full      = count_q == FULL_LVL;
    assign Afull     = count_q >= AFULL_LVL;
    assign count     = count_q;
    assign rvalid    = rvalid_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;
    // rdata shows the RAM output only in the cycle after a read, otherwise the held word
    assign rdata     = rvalid_q ? ram_rdata : rdata_q;
    // accept/reject decisions and next state; a read frees a slot for a write when full
    always_comb begin
        rd_ok    = Read_Enable && !clear && !Empty;
        wr_ok    = Write_Enable && !clear && (!Full || rd_ok);
        wr_ptr_d = clear ? '0 : wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = clear ? '0 : rd_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = clear ? '0 : (wr_ok && !rd_ok) ? count_q + 1'b1 :
                   (rd_ok && !wr_ok) ? count_q - 1'b1 : count_q;
        rvalid_d = rd_ok;
        ovf_d    = !clear && (ovf_q || (Write_Enable && !wr_ok));
        udf_d    = !clear && (udf_q || (Read_Enable && Empty));
    end
    // control state with asynchronous active-low reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rvalid_q <= rvalid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            rdata_q  <= rdata;
        end
    end
    intpol2_fifo_ram #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_ram (
        .clk     (clk),
        .we_i    (wr_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (wdata),
        .re_i    (rd_ok),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );
endmodule

// File: tb/tb_intpol2_out_fifo.sv
// tb_intpol2_out_fifo: directed vectors for the interpolator output FIFO
module tb_intpol2_out_fifo;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        clear = 1'b0;
    logic        Write_Enable = 1'b0;
    logic [31:0] wdata = '0;
    logic        Read_Enable = 1'b0;
    logic [31:0] rdata;
    logic        rvalid, Empty, Full, Afull, overflow, underflow;
    logic [4:0]  count;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] drain_exp [16];

    intpol2_out_fifo dut (
        .clk          (clk),
        .rstn         (rstn),
        .clear        (clear),
        .Write_Enable (Write_Enable),
        .wdata        (wdata),
        .Read_Enable  (Read_Enable),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .Empty        (Empty),
        .Full         (Full),
        .Afull        (Afull),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " count"}, 32'(count), 32'd0);
        check({tag, " empty"}, 32'(Empty), 32'd1);
        check({tag, " full"}, 32'(Full), 32'd0);
        check({tag, " afull"}, 32'(Afull), 32'd0);
        check({tag, " rvalid"}, 32'(rvalid), 32'd0);
        check({tag, " rdata"}, rdata, 32'd0);
        check({tag, " ovf"}, 32'(overflow), 32'd0);
        check({tag, " udf"}, 32'(underflow), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 15; i++) drain_exp[i] = 32'(i + 2);
        drain_exp[15] = 32'h55;
        step();
        step();
        check_reset_state("reset");
        rstn = 1'b1;
        // fill 0x1..0x10
        for (int i = 1; i <= 16; i++) begin
            Write_Enable = 1'b1;
            wdata = 32'(i);
            step();
            check("fill count", 32'(count), 32'(i));
            check("fill afull", 32'(Afull), 32'(i >= 12));
            check("fill full", 32'(Full), 32'(i == 16));
            check("fill empty", 32'(Empty), 32'd0);
        end
        // 17th write is dropped
        wdata = 32'hDEAD;
        step();
        Write_Enable = 1'b0;
        check("ovf flag", 32'(overflow), 32'd1);
        check("ovf count", 32'(count), 32'd16);
        check("ovf full", 32'(Full), 32'd1);
        // full with simultaneous read and write
        Write_Enable = 1'b1;
        Read_Enable = 1'b1;
        wdata = 32'h55;
        step();
        Write_Enable = 1'b0;
        check("rw count", 32'(count), 32'd16);
        check("rw rvalid", 32'(rvalid), 32'd1);
        check("rw rdata", rdata, 32'h1);
        // drain the remaining 16 words back-to-back
        for (int i = 0; i < 16; i++) begin
            step();
            check("drain rvalid", 32'(rvalid), 32'd1);
            check("drain rdata", rdata, drain_exp[i]);
            check("drain count", 32'(count), 32'(15 - i));
        end
        Read_Enable = 1'b0;
        step();
        check("idle rvalid", 32'(rvalid), 32'd0);
        check("idle rdata hold", rdata, 32'h55);
        check("drain empty", 32'(Empty), 32'd1);
        check("ovf sticky", 32'(overflow), 32'd1);
        // read on empty with simultaneous write of 0x7
        Read_Enable = 1'b1;
        Write_Enable = 1'b1;
        wdata = 32'h7;
        step();
        Write_Enable = 1'b0;
        check("udf flag", 32'(underflow), 32'd1);
        check("udf rvalid", 32'(rvalid), 32'd0);
        check("udf count", 32'(count), 32'd1);
        check("udf rdata hold", rdata, 32'h55);
        step();
        Read_Enable = 1'b0;
        check("udf next rvalid", 32'(rvalid), 32'd1);
        check("udf next rdata", rdata, 32'h7);
        check("udf next count", 32'(count), 32'd0);
        step();
        check("udf sticky", 32'(underflow), 32'd1);
        // clear with count=9, write offered during clear is discarded
        Write_Enable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            wdata = 32'(32'h100 + i);
            step();
        end
        check("pre-clear count", 32'(count), 32'd9);
        clear = 1'b1;
        step();
        clear = 1'b0;
        Write_Enable = 1'b0;
        check("clear count", 32'(count), 32'd0);
        check("clear empty", 32'(Empty), 32'd1);
        check("clear ovf", 32'(overflow), 32'd0);
        check("clear udf", 32'(underflow), 32'd0);
        check("clear rvalid", 32'(rvalid), 32'd0);
        // data written after clear starts from slot 0
        Write_Enable = 1'b1;
        wdata = 32'hA1;
        step();
        Write_Enable = 1'b0;
        Read_Enable = 1'b1;
        step();
        Read_Enable = 1'b0;
        check("post-clear rdata", rdata, 32'hA1);
        // asynchronous reset mid-fill
        Write_Enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wdata = 32'(32'h200 + i);
            step();
        end
        check("pre-rst count", 32'(count), 32'd5);
        #2;
        rstn = 1'b0;
        #1;
        check_reset_state("async rst");
        Write_Enable = 1'b0;
        step();
        rstn = 1'b1;
        check_reset_state("rst hold");
        Write_Enable = 1'b1;
        wdata = 32'hAB;
        step();
        Write_Enable = 1'b0;
        Read_Enable = 1'b1;
        step();
        Read_Enable = 1'b0;
        check("post-rst rdata", rdata, 32'hAB);
        check("post-rst empty", 32'(Empty), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
